// File: rtl/pulse_cnt_pkg.sv
// ---------------------------------------------------------------------------
// pulse_cnt_pkg
// Shared definitions for the pulse-count arbiter slice:
//   state_t          arbiter FSM encoding (IDLE, COUNT)
//   DEF_MOD_DEFAULT  period used when the programmed modulo is zero
//   rr_next()        round-robin search for the next requester to grant
// ---------------------------------------------------------------------------
package pulse_cnt_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      COUNT = 1'b1
   } state_t;

   localparam int DEF_MOD_DEFAULT = 4;
   localparam int MAX_REQ         = 8;
   localparam int MAX_IDX_W       = 3;

   // Returns the first set bit of req searching upward from last+1 with
   // wrap at n. The loop runs from the far end back toward last+1, so the
   // nearest candidate is written last and wins. Callers only use the
   // result when at least one req bit is set.
   function automatic logic [MAX_IDX_W-1:0] rr_next(
      input logic [MAX_REQ-1:0]   req,
      input logic [MAX_IDX_W-1:0] last,
      input int                   n
   );
      logic [MAX_IDX_W-1:0] idx;
      rr_next = last;
      for (int i = n; i > 0; i--) begin
         idx = MAX_IDX_W'((int'(last) + i) % n);
         if (req[idx]) rr_next = idx;
      end
   endfunction

endpackage

// File: rtl/mod_pulse_counter.sv
// ---------------------------------------------------------------------------
// mod_pulse_counter
// Programmable-modulo pulse counter shared by the arbiter.
//   clk, rst     clock and synchronous active-high reset
//   clr          return count to zero (requester abandoned)
//   load_period  capture period and clear the count (grant cycle)
//   period       modulo to capture on load_period
//   inc          count one data pulse
//   cnt          current count, registered
//   term         combinational: inc arrives while cnt == period-1
// ---------------------------------------------------------------------------
module mod_pulse_counter
   import pulse_cnt_pkg::*;
#(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             load_period,
   input  logic [CNT_W-1:0] period,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt,
   output logic             term
);

   logic [CNT_W-1:0] period_q;

   assign term = inc && (cnt == period_q - CNT_W'(1));

   // NOTE: state registers use non-blocking assignments so every flop
   // samples the pre-edge values of its neighbours.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         period_q <= '0;
      end else if (load_period) begin
         cnt      <= '0;
         period_q <= period;
      end else if (term || clr) begin
         // Wrap happens only on completion, so cnt never reaches period.
         cnt <= '0;
      end else if (inc) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/pulse_cnt_arbiter.sv
// ---------------------------------------------------------------------------
// pulse_cnt_arbiter
// Shares one modulo pulse counter among N_REQ requesters, round-robin.
//   clk, rst  clock and synchronous active-high reset
//   req       per-requester level request, held until done or abandoned
//   data      per-requester data pulse, counted for the granted one only
//   mod_val   count period, sampled in the grant cycle (0 -> DEF_MOD)
//   grant     one-hot registered grant, zero when idle
//   busy      high while counting for a granted requester
//   cnt_out   current count value
//   done      one-cycle pulse: requester reached its period
//   abort     one-cycle pulse: requester dropped req before completing
// ---------------------------------------------------------------------------
module pulse_cnt_arbiter
   import pulse_cnt_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int CNT_W   = 4,
   parameter int DEF_MOD = DEF_MOD_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] data,
   input  logic [CNT_W-1:0] mod_val,
   output logic [N_REQ-1:0] grant,
   output logic             busy,
   output logic [CNT_W-1:0] cnt_out,
   output logic [N_REQ-1:0] done,
   output logic [N_REQ-1:0] abort
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   state_t           state, next_state;
   logic [IDX_W-1:0] last_grant, last_d;
   logic [N_REQ-1:0] grant_d, done_d, abort_d;
   logic [MAX_REQ-1:0] req_ext;
   logic [CNT_W-1:0] period_sel;
   logic             load_period, inc, clr, term;

   // During COUNT last_grant is the index currently being served.
   assign req_ext     = MAX_REQ'(req);
   assign period_sel  = (mod_val == '0) ? CNT_W'(DEF_MOD) : mod_val;
   assign load_period = (state == IDLE) && (|req);
   assign inc         = (state == COUNT) && data[last_grant];
   assign clr         = (state == COUNT) && !req[last_grant];
   assign busy        = (state == COUNT);

   mod_pulse_counter #(.CNT_W(CNT_W)) u_counter (
      .clk         (clk),
      .rst         (rst),
      .clr         (clr),
      .load_period (load_period),
      .period      (period_sel),
      .inc         (inc),
      .cnt         (cnt_out),
      .term        (term)
   );

   // NOTE: every output of this block is assigned a default first, so no
   // path through the case leaves a signal unassigned and infers a latch.
   always_comb begin
      next_state = state;
      grant_d    = grant;
      last_d     = last_grant;
      done_d     = '0;
      abort_d    = '0;
      unique case (state)
         IDLE: begin
            if (|req) begin
               last_d     = IDX_W'(rr_next(req_ext, MAX_IDX_W'(last_grant), N_REQ));
               grant_d    = N_REQ'(1) << last_d;
               next_state = COUNT;
            end
         end
         COUNT: begin
            // Completion outranks a simultaneous req drop.
            if (term) begin
               done_d[last_grant] = 1'b1;
               grant_d            = '0;
               next_state         = IDLE;
            end else if (!req[last_grant]) begin
               abort_d[last_grant] = 1'b1;
               grant_d             = '0;
               next_state          = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         grant      <= '0;
         done       <= '0;
         abort      <= '0;
         // Pointing at the top index gives requester 0 first priority.
         last_grant <= IDX_W'(N_REQ - 1);
      end else begin
         state      <= next_state;
         grant      <= grant_d;
         done       <= done_d;
         abort      <= abort_d;
         last_grant <= last_d;
      end
   end

endmodule

// File: tb/tb_pulse_cnt_arbiter.sv
// ---------------------------------------------------------------------------
// tb_pulse_cnt_arbiter
// Directed stimulus pushes hand-derived output snapshots into a queue; a
// monitor samples the DUT on the falling edge and, whenever the snapshot
// changes, pops and compares the next expectation.
// ---------------------------------------------------------------------------
module tb_pulse_cnt_arbiter;

   typedef struct packed {
      logic [3:0] grant;
      logic       busy;
      logic [3:0] cnt;
      logic [3:0] done;
      logic [3:0] abort;
   } snap_t;

   typedef struct {
      string name;
      snap_t v;
   } exp_t;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic [3:0] data;
   logic [3:0] mod_val;
   logic [3:0] grant;
   logic       busy;
   logic [3:0] cnt_out;
   logic [3:0] done;
   logic [3:0] abort;

   exp_t  exp_q[$];
   int    total = 0;
   int    bad   = 0;
   bit    mon_en = 1'b0;
   bit    first  = 1'b1;
   snap_t prev;

   pulse_cnt_arbiter #(.N_REQ(4), .CNT_W(4), .DEF_MOD(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .data    (data),
      .mod_val (mod_val),
      .grant   (grant),
      .busy    (busy),
      .cnt_out (cnt_out),
      .done    (done),
      .abort   (abort)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic snap_t mk(input logic [3:0] g, input logic b,
                                input logic [3:0] c, input logic [3:0] d,
                                input logic [3:0] a);
      snap_t s;
      s.grant = g; s.busy = b; s.cnt = c; s.done = d; s.abort = a;
      return s;
   endfunction

   task automatic push(input string name, input logic [3:0] g, input logic b,
                       input logic [3:0] c, input logic [3:0] d, input logic [3:0] a);
      exp_t e;
      e.name = name;
      e.v    = mk(g, b, c, d, a);
      exp_q.push_back(e);
   endtask

   task automatic check(input string name, input snap_t act, input snap_t exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got grant=%b busy=%b cnt=%0d done=%b abort=%b, want grant=%b busy=%b cnt=%0d done=%b abort=%b",
                  name, act.grant, act.busy, act.cnt, act.done, act.abort,
                  exp.grant, exp.busy, exp.cnt, exp.done, exp.abort);
      end
   endtask

   // One clock of stimulus: drive, let the edge happen, settle past it.
   task automatic cyc(input logic [3:0] r, input logic [3:0] d, input logic [3:0] m);
      req = r; data = d; mod_val = m;
      @(posedge clk);
      #1;
   endtask

   // Monitor: any change of the output snapshot is a presented response.
   always @(negedge clk) begin
      snap_t cur;
      exp_t  e;
      if (mon_en) begin
         cur = mk(grant, busy, cnt_out, done, abort);
         if (first || cur !== prev) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected: got grant=%b busy=%b cnt=%0d done=%b abort=%b, want no change",
                        cur.grant, cur.busy, cur.cnt, cur.done, cur.abort);
            end else begin
               e = exp_q.pop_front();
               check(e.name, cur, e.v);
            end
            prev  = cur;
            first = 1'b0;
         end
      end
   end

   initial begin
      exp_t e;
      rst = 1'b1; req = '0; data = '0; mod_val = '0;

      // Reset then idle: outputs at reset values for the whole reset window.
      push("reset", 4'b0000, 1'b0, 4'd0, 4'b0000, 4'b0000);
      @(posedge clk); #1;
      mon_en = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;

      // Round-robin, period 2, all requesting with data every cycle.
      for (int k = 0; k < 5; k++) begin
         push("rr_grant", 4'b0001 << (k % 4), 1'b1, 4'd0, 4'b0000, 4'b0000);
         push("rr_cnt1",  4'b0001 << (k % 4), 1'b1, 4'd1, 4'b0000, 4'b0000);
         push("rr_done",  4'b0000, 1'b0, 4'd0, 4'b0001 << (k % 4), 4'b0000);
      end
      repeat (15) cyc(4'b1111, 4'b1111, 4'd2);
      push("rr_idle", 4'b0000, 1'b0, 4'd0, 4'b0000, 4'b0000);
      cyc(4'b0000, 4'b0000, 4'd2);

      // Single requester, default period; data in the grant cycle is ignored.
      push("def_grant", 4'b0001, 1'b1, 4'd0, 4'b0000, 4'b0000);
      cyc(4'b0001, 4'b0001, 4'd0);
      push("def_cnt1", 4'b0001, 1'b1, 4'd1, 4'b0000, 4'b0000);
      cyc(4'b0001, 4'b0001, 4'd0);
      cyc(4'b0001, 4'b0000, 4'd0);
      push("def_cnt2", 4'b0001, 1'b1, 4'd2, 4'b0000, 4'b0000);
      cyc(4'b0001, 4'b0001, 4'd0);
      cyc(4'b0001, 4'b0000, 4'd0);
      push("def_cnt3", 4'b0001, 1'b1, 4'd3, 4'b0000, 4'b0000);
      cyc(4'b0001, 4'b0001, 4'd0);
      cyc(4'b0001, 4'b0000, 4'd0);
      push("def_done", 4'b0000, 1'b0, 4'd0, 4'b0001, 4'b0000);
      cyc(4'b0001, 4'b0001, 4'd0);
      push("def_idle", 4'b0000, 1'b0, 4'd0, 4'b0000, 4'b0000);
      cyc(4'b0000, 4'b0000, 4'd0);

      // Abort: grant 0100 with period 5; mod_val changes mid-count ignored.
      push("ab_grant", 4'b0100, 1'b1, 4'd0, 4'b0000, 4'b0000);
      cyc(4'b0100, 4'b0000, 4'd5);
      push("ab_cnt1", 4'b0100, 1'b1, 4'd1, 4'b0000, 4'b0000);
      cyc(4'b0100, 4'b0100, 4'd1);
      push("ab_cnt2", 4'b0100, 1'b1, 4'd2, 4'b0000, 4'b0000);
      cyc(4'b0100, 4'b0100, 4'd1);
      push("ab_abort", 4'b0000, 1'b0, 4'd0, 4'b0000, 4'b0100);
      cyc(4'b1001, 4'b0000, 4'd3);
      // Next pending above index 2 is 3; period 3 latched here.
      push("ab_next", 4'b1000, 1'b1, 4'd0, 4'b0000, 4'b0000);
      cyc(4'b1001, 4'b0000, 4'd3);
      push("sim_cnt1", 4'b1000, 1'b1, 4'd1, 4'b0000, 4'b0000);
      cyc(4'b1001, 4'b1000, 4'd0);
      push("sim_cnt2", 4'b1000, 1'b1, 4'd2, 4'b0000, 4'b0000);
      cyc(4'b1001, 4'b1000, 4'd0);
      // Final pulse with req[3] dropped in the same cycle: done, not abort.
      push("sim_done", 4'b0000, 1'b0, 4'd0, 4'b1000, 4'b0000);
      cyc(4'b0001, 4'b1000, 4'd0);
      push("sim_idle", 4'b0000, 1'b0, 4'd0, 4'b0000, 4'b0000);
      cyc(4'b0000, 4'b0000, 4'd0);

      // Reset mid-count under grant 0010.
      push("rc_grant", 4'b0010, 1'b1, 4'd0, 4'b0000, 4'b0000);
      cyc(4'b0010, 4'b0000, 4'd0);
      push("rc_cnt1", 4'b0010, 1'b1, 4'd1, 4'b0000, 4'b0000);
      cyc(4'b0010, 4'b0010, 4'd0);
      push("rc_cnt2", 4'b0010, 1'b1, 4'd2, 4'b0000, 4'b0000);
      cyc(4'b0010, 4'b0010, 4'd0);
      rst = 1'b1;
      push("rc_reset", 4'b0000, 1'b0, 4'd0, 4'b0000, 4'b0000);
      cyc(4'b1111, 4'b0010, 4'd0);
      rst = 1'b0;
      push("rc_first", 4'b0001, 1'b1, 4'd0, 4'b0000, 4'b0000);
      cyc(4'b1111, 4'b0000, 4'd0);
      push("rc_abort", 4'b0000, 1'b0, 4'd0, 4'b0000, 4'b0001);
      cyc(4'b0000, 4'b0000, 4'd0);
      push("rc_idle", 4'b0000, 1'b0, 4'd0, 4'b0000, 4'b0000);
      cyc(4'b0000, 4'b0000, 4'd0);

      repeat (3) cyc(4'b0000, 4'b0000, 4'd0);

      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         total++;
         bad++;
         $display("FAIL %s: got no response, want grant=%b busy=%b cnt=%0d done=%b abort=%b",
                  e.name, e.v.grant, e.v.busy, e.v.cnt, e.v.done, e.v.abort);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pulse_cnt_arbiter.md
Name: pulse_cnt_arbiter

Overview:
- Shares one programmable-modulo data-pulse counter among N_REQ requesters, using round-robin arbitration.
- The granted requester's data pulses are counted until the programmed period is reached. Completion then raises a one-cycle done pulse for that requester, and the counter is released.
- Sits upstream of the pulse-count FSMs. It sequences the single counter resource and configures its period at grant time.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- CNT_W, 4, counter and period width
- DEF_MOD, 4, period used when mod_val is 0

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- req  input  N_REQ  per-requester access request, level; held until done or abandoned
- data  input  N_REQ  per-requester data pulse; counted only for the granted requester
- mod_val  input  CNT_W  count period, sampled on the grant cycle only
- grant  output  N_REQ  one-hot grant, registered; all zero when idle
- busy  output  1  high while state is COUNT
- cnt_out  output  CNT_W  current count value
- done  output  N_REQ  one-cycle pulse: requester completed mod_val pulses
- abort  output  N_REQ  one-cycle pulse: requester dropped req before completion

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. All outputs are registered.
- Reset values: grant=0, busy=0, cnt_out=0, done=0, abort=0, state=IDLE, last_grant=N_REQ-1 (so requester 0 has first priority).
- Reset asserted mid-operation: everything returns to the reset values on the next edge. No done or abort is emitted.
- States: IDLE, COUNT.
- IDLE, at each edge:
  - If any req bit is set, select the first set bit searching upward from last_grant+1 with wrap.
  - Set grant to that one-hot, record last_grant, latch period = (mod_val==0 ? DEF_MOD : mod_val), clear cnt, go to COUNT.
  - If no req bit is set, stay in IDLE.
- COUNT, g = granted index, priorities evaluated each edge:
  1. data[g]=1 and cnt==period-1 (completion): done[g]=1 for one cycle, cnt->0, grant->0, go to IDLE.
  2. else req[g]=0: abort[g]=1 for one cycle, cnt->0, grant->0, go to IDLE. No done.
  3. else data[g]=1: cnt<=cnt+1.
  4. else: hold.
- data bits of non-granted requesters are ignored in every state. A data pulse in the grant cycle itself, i.e. while still in IDLE, is not counted.
- Simultaneous completion and req drop: completion wins, so done is asserted and abort is not.
- Period 1: the first counted data pulse completes.
- cnt never reaches period. Wrap is to 0 on completion only.
- Latency:
  - Grant appears 1 cycle after req is seen in IDLE.
  - done appears on the edge that samples the final data pulse.
  - Minimum gap between consecutive grants is 1 idle cycle.
  - Back-to-back: a requester still holding req after done re-competes, with round-robin fairness applied.
- mod_val changes during COUNT have no effect until the next grant.

Decomposition:
- Package pulse_cnt_pkg: state encoding (IDLE, COUNT), DEF_MOD default, and a helper function for the round-robin next-index search.
- Sub-module mod_pulse_counter, instanced once:
  - Inputs: clr, load_period, period, inc.
  - Outputs: cnt, term, where term = inc and cnt==period-1.
  - term combinationally flags completion.
- The arbiter FSM, grant register and pulse outputs stay in pulse_cnt_arbiter.

Test Plan:
- Reset then idle: rst=1 for 2 cycles with req=0 -> grant=0, busy=0, cnt_out=0, done=0, abort=0 throughout.
- Single requester, default period: req=0001, mod_val=0, four data[0] pulses with gaps -> grant=0001 one cycle after req; cnt_out goes 1,2,3; on the 4th pulse done=0001 for 1 cycle, grant=0, cnt_out=0.
- Round-robin: req=1111 held, mod_val=2, data=1111 every cycle -> grant order 0001, 0010, 0100, 1000, 0001. Each grant lasts 2 cycles, with 1 idle cycle between grants.
- Abort: grant=0100, period=5, two data[2] pulses, then req[2] dropped -> abort=0100 for 1 cycle, no done, cnt_out=0; next grant goes to the next pending requester above index 2.
- Simultaneous completion and req drop: period=3, cnt=2, data[g]=1 with req[g]=0 in the same cycle -> done[g]=1, abort=0.
- Reset mid-count: cnt_out=2 under grant 0010, rst=1 for 1 cycle -> grant=0, cnt_out=0, no done or abort; with req=1111 afterwards, the first grant is 0001.
